// File: rtl/pos_encode_ctrl.sv
// Debounced one-hot key to 4-bit position encoder
// with valid/ready offer and release lockout.
module pos_encode_ctrl #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] key_in,
  output logic [3:0]  pos_out,
  output logic        pos_valid,
  input  logic        pos_ready,
  output logic        multi_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    OFFER,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      cap;
  logic             any_key;
  logic             multi;

  function automatic logic [3:0] encode(
    input logic [15:0] v
  );
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (v[i]) r = 4'(i);
    return r;
  endfunction

  assign any_key = |key_in;
  assign multi = |(key_in & (key_in - 16'd1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap       <= '0;
      pos_out   <= '0;
      pos_valid <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      multi_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && any_key) begin
            cnt <= '0;
            if (multi) begin
              multi_err <= 1'b1;
              state     <= RELEASE;
            end else begin
              cap   <= key_in;
              state <= DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!en) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (key_in != cap) begin
            cnt <= '0;
            if (multi) begin
              multi_err <= 1'b1;
              state     <= RELEASE;
            end else begin
              state <= IDLE;
            end
          end else if (cnt == LAST) begin
            pos_out   <= encode(cap);
            pos_valid <= 1'b1;
            cnt       <= '0;
            state     <= OFFER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OFFER: begin
          if (pos_valid && pos_ready) begin
            pos_valid <= 1'b0;
            cnt       <= '0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          // any key activity restarts the quiet window
          if (any_key) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pos_encode_ctrl.sv
// Self-checking bench for pos_encode_ctrl:
// cycle vector table plus directed corner sequences.
module tb_pos_encode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] key_in;
  logic [3:0]  pos_out;
  logic        pos_valid;
  logic        pos_ready;
  logic        multi_err;
  logic        busy;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [15:0] key;
    logic        en;
    logic        rdy;
    logic        v;
    logic [3:0]  p;
    logic        e;
    logic        b;
  } vec_t;

  vec_t tbl[$];

  pos_encode_ctrl #(
    .STABLE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .key_in(key_in),
    .pos_out(pos_out),
    .pos_valid(pos_valid),
    .pos_ready(pos_ready),
    .multi_err(multi_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic [15:0] k, input logic e_n,
    input logic r, input logic v, input logic [3:0] p,
    input logic er, input logic b);
    vec_t t;
    t.key = k; t.en = e_n; t.rdy = r;
    t.v = v; t.p = p; t.e = er; t.b = b;
    return t;
  endfunction

  task automatic add(input vec_t t, input int n);
    for (int i = 0; i < n; i++) tbl.push_back(t);
  endtask

  function automatic logic [15:0] decode(
    input logic [3:0] p, input logic e_n);
    logic [15:0] one;
    one = 16'd1;
    return e_n ? (one << p) : 16'd0;
  endfunction

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!pos_valid && n < 20) begin
      step();
      n++;
    end
    chk(name, pos_valid, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk(name, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    key_in = '0;
    pos_ready = 1'b0;
    #12;
    chk("rst_valid", pos_valid, 0);
    chk("rst_pos", pos_out, 0);
    chk("rst_err", multi_err, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single key, ready already high
    add(mk(16'h0001, 1, 1, 0, 0, 0, 1), 4);
    add(mk(16'h0001, 1, 1, 1, 0, 0, 1), 1);
    add(mk(16'h0001, 1, 1, 0, 0, 0, 1), 2);
    add(mk(16'h0000, 1, 1, 0, 0, 0, 1), 3);
    add(mk(16'h0000, 1, 1, 0, 0, 0, 0), 1);
    // multi-key press then clean retry
    add(mk(16'h0030, 1, 1, 0, 0, 1, 1), 1);
    add(mk(16'h0030, 1, 1, 0, 0, 0, 1), 1);
    add(mk(16'h0000, 1, 1, 0, 0, 0, 1), 3);
    add(mk(16'h0000, 1, 1, 0, 0, 0, 0), 1);
    add(mk(16'h0020, 1, 1, 0, 0, 0, 1), 4);
    add(mk(16'h0020, 1, 1, 1, 5, 0, 1), 1);
    add(mk(16'h0020, 1, 1, 0, 0, 0, 1), 1);
    add(mk(16'h0000, 1, 1, 0, 0, 0, 1), 3);
    add(mk(16'h0000, 1, 1, 0, 0, 0, 0), 1);
    // en gating, then bounce to another key
    add(mk(16'h0001, 0, 1, 0, 0, 0, 0), 2);
    add(mk(16'h0004, 1, 1, 0, 0, 0, 1), 2);
    add(mk(16'h0008, 1, 1, 0, 0, 0, 0), 1);
    add(mk(16'h0008, 1, 1, 0, 0, 0, 1), 4);
    add(mk(16'h0008, 1, 1, 1, 3, 0, 1), 1);
    add(mk(16'h0000, 1, 1, 0, 0, 0, 1), 4);
    add(mk(16'h0000, 1, 1, 0, 0, 0, 0), 1);

    foreach (tbl[i]) begin
      key_in = tbl[i].key;
      en = tbl[i].en;
      pos_ready = tbl[i].rdy;
      step();
      chk($sformatf("v%0d_valid", i),
          pos_valid, tbl[i].v);
      chk($sformatf("v%0d_err", i),
          multi_err, tbl[i].e);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].b);
      if (tbl[i].v)
        chk($sformatf("v%0d_pos", i),
            pos_out, tbl[i].p);
    end

    // backpressure: offer held while ready low
    key_in = 16'h8000;
    en = 1'b1;
    pos_ready = 1'b0;
    repeat (5) step();
    chk("bp_valid_rise", pos_valid, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) en = 1'b0;
      if (i == 7) key_in = 16'h0000;
      step();
      chk("bp_hold_valid", pos_valid, 1);
      chk("bp_hold_pos", pos_out, 15);
    end
    key_in = 16'h8000;
    en = 1'b1;
    pos_ready = 1'b1;
    step();
    chk("bp_xfer", pos_valid, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_no_second", pos_valid, 0);
      chk("bp_busy", busy, 1);
    end
    key_in = '0;
    repeat (4) step();
    chk("bp_idle", busy, 0);

    // every code round-trips through a decoder
    for (int k = 0; k < 16; k++) begin
      logic [15:0] code;
      code = 16'd1 << k;
      key_in = code;
      wait_valid($sformatf("rt%0d_valid", k));
      chk($sformatf("rt%0d_dec", k),
          int'(decode(pos_out, 1'b1)), int'(code));
      key_in = '0;
      wait_idle($sformatf("rt%0d_idle", k));
    end

    // async reset during an offer
    pos_ready = 1'b0;
    key_in = 16'h0400;
    repeat (5) step();
    chk("ar_valid", pos_valid, 1);
    chk("ar_pos", pos_out, 10);
    rst_n = 1'b0;
    #1;
    chk("ar_drop_valid", pos_valid, 0);
    chk("ar_drop_pos", pos_out, 0);
    chk("ar_drop_busy", busy, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ar_redebounce", pos_valid, 0);
    end
    step();
    chk("ar_valid_again", pos_valid, 1);
    chk("ar_pos_again", pos_out, 10);
    pos_ready = 1'b1;
    step();
    chk("ar_xfer", pos_valid, 0);
    key_in = '0;
    wait_idle("ar_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
